// File: rtl/mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// mem_bridge_pkg
//   Shared definitions for the CPU memory-port bridge.
//   - bridge_state_e : FSM state encoding (IDLE=0 .. WAIT_I=4); the values are
//                      part of the debug view, so keep them stable.
//   - ADDR_MASK_DEFAULT : kseg0/kseg1 -> physical address mask.
//   - WSTRB_NONE     : byte-enable pattern that marks a store as a no-op.
//   - is_null_store  : a store with no enabled bytes never touches memory.
// -----------------------------------------------------------------------------
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_D  = 3'd1,
        WAIT_D = 3'd2,
        REQ_I  = 3'd3,
        WAIT_I = 3'd4
    } bridge_state_e;

    localparam logic [31:0] ADDR_MASK_DEFAULT = 32'h1fff_ffff;
    localparam logic [3:0]  WSTRB_NONE        = 4'b0000;

    function automatic logic is_null_store(input logic wr, input logic [3:0] wstrb);
        return wr && (wstrb == WSTRB_NONE);
    endfunction

endpackage

// File: rtl/mem_port_bridge.sv
// -----------------------------------------------------------------------------
// mem_port_bridge
//   Merges the datapath's instruction-fetch and data-access requests onto a
//   single handshaked memory port. One transaction is outstanding at a time;
//   on a simultaneous request the data side wins when DATA_FIRST=1.
//
// Handshake semantics (all sides):
//   x_req is a level held by the requester until x_addr_ok. x_addr_ok is a
//   combinational one-cycle pulse, only ever raised while the bridge is IDLE,
//   and marks the cycle the request fields are captured. x_data_ok is a
//   registered one-cycle pulse; x_rdata is valid with it and held until the
//   next read completion of that side. Towards memory, mem_req is held with
//   stable fields until mem_addr_ok; mem_data_ok is only honoured in WAIT_x.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   inst_req/addr         fetch request (level) and virtual address
//   inst_addr_ok/data_ok  fetch accept / completion pulses
//   inst_rdata            last fetched word
//   data_req/wr/wstrb/addr/wdata   data request (level), store flag, byte
//                         enables, virtual address, store data
//   data_addr_ok/data_ok  data accept / completion pulses
//   data_rdata            last loaded word
//   mem_req/wr/wstrb/addr/wdata    request to memory (masked address)
//   mem_addr_ok/data_ok/rdata      memory accept, response, read data
//   busy                  1 whenever the FSM is not IDLE
//   dbg_state             current FSM state (bridge_state_e encoding)
// -----------------------------------------------------------------------------
module mem_port_bridge
    import mem_bridge_pkg::*;
#(
    parameter logic [31:0] ADDR_MASK  = ADDR_MASK_DEFAULT,
    parameter bit          DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic [2:0]  dbg_state
);

    bridge_state_e state;

    logic        in_idle;
    logic        data_pick;
    logic        inst_pick;
    logic        null_store;
    logic        capture_data;
    logic        capture_inst;

    // Captured-request register bank; drives the memory port directly.
    logic        req_wr_q;
    logic [3:0]  req_wstrb_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;

    logic        inst_data_ok_q;
    logic        data_data_ok_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;

    assign in_idle = (state == IDLE);

    // Arbitration. Gated by reset so no accept pulse can leak out while the
    // bridge is held in reset with a request already pending.
    always_comb begin
        data_pick = 1'b0;
        inst_pick = 1'b0;
        if (in_idle && reset) begin
            if (DATA_FIRST) begin
                data_pick = data_req;
                inst_pick = inst_req & ~data_req;
            end else begin
                inst_pick = inst_req;
                data_pick = data_req & ~inst_req;
            end
        end
    end

    // An all-zero store is acknowledged and completed locally: nothing is
    // captured and the FSM does not leave IDLE.
    assign null_store   = data_pick & is_null_store(data_wr, data_wstrb);
    assign capture_data = data_pick & ~null_store;
    assign capture_inst = inst_pick;

    assign inst_addr_ok = inst_pick;
    assign data_addr_ok = data_pick;

    // Request bank. Loads carry no byte enables; fetches carry neither byte
    // enables nor store data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_wr_q    <= 1'b0;
            req_wstrb_q <= WSTRB_NONE;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
        end else if (capture_data) begin
            req_wr_q    <= data_wr;
            req_wstrb_q <= data_wr ? data_wstrb : WSTRB_NONE;
            req_addr_q  <= data_addr & ADDR_MASK;
            req_wdata_q <= data_wdata;
        end else if (capture_inst) begin
            req_wr_q    <= 1'b0;
            req_wstrb_q <= WSTRB_NONE;
            req_addr_q  <= inst_addr & ADDR_MASK;
            req_wdata_q <= 32'h0;
        end
    end

    // Main FSM. Completion pulses are registered so they appear in the IDLE
    // cycle after mem_data_ok, together with the updated read data; a new
    // request may be accepted in that same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= 32'h0;
            data_rdata_q   <= 32'h0;
        end else begin
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (null_store) begin
                        data_data_ok_q <= 1'b1;
                    end else if (capture_data) begin
                        state <= REQ_D;
                    end else if (capture_inst) begin
                        state <= REQ_I;
                    end
                end
                REQ_D: begin
                    if (mem_addr_ok) begin
                        state <= WAIT_D;
                    end
                end
                REQ_I: begin
                    if (mem_addr_ok) begin
                        state <= WAIT_I;
                    end
                end
                WAIT_D: begin
                    if (mem_data_ok) begin
                        state          <= IDLE;
                        data_data_ok_q <= 1'b1;
                        if (!req_wr_q) begin
                            data_rdata_q <= mem_rdata;
                        end
                    end
                end
                WAIT_I: begin
                    if (mem_data_ok) begin
                        state          <= IDLE;
                        inst_data_ok_q <= 1'b1;
                        inst_rdata_q   <= mem_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req      = (state == REQ_D) || (state == REQ_I);
    assign mem_wr       = req_wr_q;
    assign mem_wstrb    = req_wstrb_q;
    assign mem_addr     = req_addr_q;
    assign mem_wdata    = req_wdata_q;

    assign inst_data_ok = inst_data_ok_q;
    assign data_data_ok = data_data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

    assign busy         = !in_idle;
    assign dbg_state    = state;

endmodule
